reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised general-purpose register file with write-to-read bypass and a per-register
//  pending-write scoreboard. Sits in the decode stage: N read ports feed operands, one writeback
//  port from WB, one issue port marking destinations busy until written back. Busy flags drive
//  hazard/stall logic.
// PARAMETERS
//  XLEN    32       register width in bits
//  NREGS   32       register count (power of 2, >=2); AW = $clog2(NREGS)
//  NRD     2        number of read ports (1..4)
//  SP_IDX  2        register index loaded with SP_INIT at reset
//  SP_INIT 'h200    reset value of register SP_IDX (XLEN bits)
//  BYPASS  1        1: same-cycle WB data forwarded to read ports; 0: read returns stored value
// PORTS
//  clk       in   1         clock; all state updates on posedge
//  rst_n     in   1         asynchronous active-low reset
//  rd_addr   in   NRD*AW    packed read addresses, port k at [k*AW +: AW]
//  rd_data   out  NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN]
//  rd_busy   out  NRD       port k's register has a pending write
//  wr_en     in   1         writeback enable
//  wr_addr   in   AW        writeback destination
//  wr_data   in   XLEN      writeback data
//  iss_en    in   1         issue request: mark iss_rd pending
//  iss_rd    in   AW        destination being issued
//  iss_stall out  1         issue refused this cycle (WAW on busy register)
//  flush     in   1         clear all pending flags (pipeline flush)
//  busy_cnt  out  AW+1      number of registers currently pending
// BEHAVIOUR
//  Reset (rst_n=0, async): regs[i]=0 for all i, regs[SP_IDX]=SP_INIT; busy[*]=0; busy_cnt=0.
//   Outputs are combinational from that state. Reset mid-operation discards pending writes.
//  Register 0: always reads 0, never busy; writes and issues to 0 are ignored (no stall).
//  Write: posedge clk, wr_en && wr_addr!=0 -> regs[wr_addr]<=wr_data; busy[wr_addr]<=0.
//  Read: combinational, zero latency. BYPASS=1 and wr_en && wr_addr==rd_addr[k]!=0
//   -> rd_data[k]=wr_data, else regs[rd_addr[k]]. Multiple ports may read one address.
//  rd_busy[k] = busy[rd_addr[k]] && !(BYPASS && wr_en && wr_addr==rd_addr[k]).
//  Issue: hit = wr_en && wr_addr==iss_rd.
//   iss_stall = iss_en && iss_rd!=0 && busy[iss_rd] && !hit && !flush.
//   iss_en && iss_rd!=0 && !iss_stall -> busy[iss_rd]<=1 at posedge.
//  Simultaneous events on the same register in one cycle, priority high->low:
//   1 issue set (a newer producer wins over a completing older one; the data is still written)
//   2 writeback clear
//   3 flush: busy[*]<=0 except the accepted issue; flush + issue -> exactly that bit set
//  Writeback to a non-busy register is legal: writes data, busy stays 0.
//  busy_cnt: registered population count of busy[], updated with busy[], range 0..NREGS-1.
//   Reaches NREGS-1 max because reg 0 is never busy; no overflow is possible.
//  No other state. No internal FSM beyond the busy vector; no multi-cycle latency.
// STRUCTURE
//  Shared package rf_pkg: XLEN/NREGS defaults, typedef reg_addr_t (logic[AW-1:0]),
//   typedef xword_t (logic[XLEN-1:0]), localparam REG_ZERO=0.
//  One sub-module: rf_scoreboard (busy vector, issue/stall/flush/priority logic, busy_cnt).
//   Storage, bypass muxes and read ports stay in reg_file_sb.
//  Storage is flops with async reset. No RAM macro, due to the reset and SP_INIT requirements.
// TESTING
//  1 Reset: pulse rst_n low mid-cycle -> all rd_data=0 except addr 2 reads 'h200; busy_cnt=0.
//  2 Write/bypass: wr x5='hDEADBEEF, rd_addr0=5 same cycle -> rd_data0='hDEADBEEF
//    (BYPASS=1) or old 0 (BYPASS=0); next cycle both configurations give 'hDEADBEEF.
//  3 x0: wr x0='h1234, iss x0 -> rd x0=0, rd_busy=0, iss_stall=0, busy_cnt unchanged.
//  4 Scoreboard: iss x7 -> next cycle rd_busy for x7=1, busy_cnt=1; iss x7 again -> iss_stall=1;
//    then wb x7='h55 -> rd_busy=0 combinationally (BYPASS=1), busy_cnt=0 next cycle.
//  5 Collisions: x9 busy; iss x9 + wb x9='hA in the same cycle -> no stall, regs[9]='hA,
//    x9 still busy. Iss x3 + flush with x4,x9 busy -> only x3 busy, busy_cnt=1.
//  6 Fill: issue x1..x31 on consecutive cycles -> busy_cnt=31; flush -> 0; then random
//    traffic checked against a reference model for all NRD ports.

Source files
------------

// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
//   Shared definitions for the reg_file_sb register file slice.
//   - Default geometry (XLEN_DEF / NREGS_DEF) used as parameter defaults.
//   - reg_addr_t / xword_t typedefs for the default geometry.
//   - REG_ZERO: the hard-wired zero register index.
//   - popcount(): population count of a busy vector.
// ----------------------------------------------------------------------------
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    localparam int REG_ZERO  = 0;

    // Widest busy vector supported by popcount().
    localparam int POP_MAX   = 1024;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

    // Count of set bits in the low 'width' bits of 'vec'.
    function automatic int unsigned popcount(input logic [POP_MAX-1:0] vec,
                                             input int unsigned width);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < POP_MAX; i++) begin
            if (i < width && vec[i]) begin
                cnt++;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// ----------------------------------------------------------------------------
// reg_file_sb_if
//   Bundles the register file's decode-stage signals.
//   master : decode/issue/writeback side (drives addresses, writeback, issue)
//   slave  : the register file (returns operands, busy flags, stall, count)
//   Signals:
//     rd_addr   NRD*AW    packed read addresses, port k at [k*AW +: AW]
//     rd_data   NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN]
//     rd_busy   NRD       port k's register has a pending write
//     wr_en/wr_addr/wr_data  writeback port
//     iss_en/iss_rd          issue port (mark destination pending)
//     iss_stall              issue refused this cycle (WAW on busy register)
//     flush                  clear all pending flags
//     busy_cnt  AW+1      number of registers currently pending
// ----------------------------------------------------------------------------
interface reg_file_sb_if #(
    parameter int XLEN  = rf_pkg::XLEN_DEF,
    parameter int NREGS = rf_pkg::NREGS_DEF,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_rd;
    logic                iss_stall;
    logic                flush;
    logic [AW:0]         busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
        input  rd_data, rd_busy, iss_stall, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
        output rd_data, rd_busy, iss_stall, busy_cnt
    );

endinterface

// File: rtl/rf_scoreboard.sv
// ----------------------------------------------------------------------------
// rf_scoreboard
//   Pending-write tracker for the register file.
//   Ports:
//     clk, rst_n          clock / async active-low reset
//     wr_en, wr_addr      writeback completes: clears the destination's flag
//     iss_en, iss_rd      issue: sets the destination's flag unless stalled
//     flush               clears every flag except a same-cycle accepted issue
//     iss_stall  (out)    WAW refusal: destination busy, not completing now
//     busy       (out)    registered pending vector, bit 0 always 0
//     busy_cnt   (out)    registered population count of busy
//   Same-register priority: issue set > writeback clear > flush.
// ----------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    input  logic             flush,
    output logic             iss_stall,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    logic             wr_live;
    logic             iss_live;
    logic             iss_hit;
    logic             iss_accept;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      cnt_d;

    assign wr_live  = wr_en  && (wr_addr != AW'(REG_ZERO));
    assign iss_live = iss_en && (iss_rd  != AW'(REG_ZERO));
    // A writeback landing on the issued register this cycle frees it, so the
    // newer producer may take it over without stalling.
    assign iss_hit  = wr_en && (wr_addr == iss_rd);

    assign iss_stall  = iss_live && busy[iss_rd] && !iss_hit && !flush;
    assign iss_accept = iss_live && !iss_stall;

    // Later assignments override earlier ones: this ordering is the priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        busy_d = busy;
        if (flush) begin
            busy_d = '0;
        end
        if (wr_live) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (iss_accept) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    // Count follows the next-state vector so it is registered in step with busy.
    assign cnt_d = (AW+1)'(popcount(POP_MAX'(busy_d), NREGS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values, independent of statement order.
            busy     <= busy_d;
            busy_cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// ----------------------------------------------------------------------------
// reg_file_sb
//   General-purpose register file with write-to-read bypass and a per-register
//   pending-write scoreboard, for use in the decode stage.
//   Ports:
//     clk, rst_n   clock / async active-low reset
//     bus          reg_file_sb_if.slave: NRD read ports, writeback port,
//                  issue port, flush, stall and busy count
//   Parameters: XLEN, NREGS, NRD, SP_IDX/SP_INIT (stack pointer reset value),
//   BYPASS (forward same-cycle writeback data and clear read-side busy).
//   Register 0 reads as 0, is never busy and ignores writes and issues.
// ----------------------------------------------------------------------------
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int               XLEN    = XLEN_DEF,
    parameter int               NREGS   = NREGS_DEF,
    parameter int               NRD     = 2,
    parameter int               SP_IDX  = 2,
    parameter logic [XLEN-1:0]  SP_INIT = XLEN'('h200),
    parameter bit               BYPASS  = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_sb_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    // ---------------------------------------------------------------- storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is plain flops, not a RAM, precisely so that every
            // entry can be reset and the stack pointer can have a reset value.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (bus.wr_en && bus.wr_addr != AW'(REG_ZERO)) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // ------------------------------------------------------------- scoreboard
    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .iss_en    (bus.iss_en),
        .iss_rd    (bus.iss_rd),
        .flush     (bus.flush),
        .iss_stall (bus.iss_stall),
        .busy      (busy),
        .busy_cnt  (bus.busy_cnt)
    );

    // ------------------------------------------------------------- read ports
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          fwd;

        assign addr = bus.rd_addr[k*AW +: AW];
        // Forwarding also hides the busy flag: the operand is arriving now.
        assign fwd  = BYPASS && bus.wr_en && (bus.wr_addr == addr)
                      && (addr != AW'(REG_ZERO));

        assign bus.rd_data[k*XLEN +: XLEN] =
            (addr == AW'(REG_ZERO)) ? '0          :
            fwd                     ? bus.wr_data : regs[addr];

        assign bus.rd_busy[k] = busy[addr] && !fwd;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// ----------------------------------------------------------------------------
// tb_reg_file_sb
//   Scoreboard bench for reg_file_sb. A driver applies one input vector per
//   cycle shortly after the rising edge, derives the expected outputs from a
//   behavioural model (register array + set of pending registers) and queues
//   them; a monitor pops and compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_reg_file_sb;

    localparam int              XLEN    = 32;
    localparam int              NREGS   = 32;
    localparam int              NRD     = 2;
    localparam int              AW      = $clog2(NREGS);
    localparam int              SP_IDX  = 2;
    localparam logic [XLEN-1:0] SP_INIT = 32'h200;
    localparam bit              BYPASS  = 1'b1;

    typedef struct packed {
        logic [NRD*XLEN-1:0] data;
        logic [NRD-1:0]      busy;
        logic                stall;
        logic [AW:0]         cnt;
        logic [31:0]         cyc;
    } exp_t;

    logic clk;
    logic rst_n;

    reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    reg_file_sb #(
        .XLEN    (XLEN),
        .NREGS   (NREGS),
        .NRD     (NRD),
        .SP_IDX  (SP_IDX),
        .SP_INIT (SP_INIT),
        .BYPASS  (BYPASS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t exp_q[$];

    // Reference model: register contents plus the set of pending registers.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [int];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_regs[SP_IDX] = SP_INIT;
        m_busy.delete();
    endtask

    // One clock of stimulus: drive, predict, queue, advance the model.
    task automatic step(input int r0, input int r1,
                        input bit we, input int wa, input logic [XLEN-1:0] wd,
                        input bit ie, input int ir, input bit fl);
        exp_t e;
        int   ra [NRD];
        bit   fwd;
        bit   hit;
        @(posedge clk);
        #1;
        cyc++;
        ra[0] = r0;
        ra[1] = r1;
        for (int k = 0; k < NRD; k++) bus.rd_addr[k*AW +: AW] = AW'(ra[k]);
        bus.wr_en   = we;
        bus.wr_addr = AW'(wa);
        bus.wr_data = wd;
        bus.iss_en  = ie;
        bus.iss_rd  = AW'(ir);
        bus.flush   = fl;

        for (int k = 0; k < NRD; k++) begin
            fwd = BYPASS && we && (wa == ra[k]) && (ra[k] != 0);
            if (ra[k] == 0)  e.data[k*XLEN +: XLEN] = '0;
            else if (fwd)    e.data[k*XLEN +: XLEN] = wd;
            else             e.data[k*XLEN +: XLEN] = m_regs[ra[k]];
            e.busy[k] = m_busy.exists(ra[k]) && !fwd;
        end
        hit     = we && (wa == ir);
        e.stall = ie && (ir != 0) && m_busy.exists(ir) && !hit && !fl;
        e.cnt   = (AW+1)'(m_busy.num());
        e.cyc   = cyc;
        exp_q.push_back(e);

        if (rst_n) begin
            if (fl) m_busy.delete();
            if (we && wa != 0) begin
                m_regs[wa] = wd;
                if (m_busy.exists(wa)) m_busy.delete(wa);
            end
            if (ie && ir != 0 && !e.stall) m_busy[ir] = 1'b1;
        end
    endtask

    task automatic idle(input int r0, input int r1);
        step(r0, r1, 1'b0, 0, '0, 1'b0, 0, 1'b0);
    endtask

    // Monitor: compares whatever the driver queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < NRD; k++) begin
                    check($sformatf("c%0d rd_data%0d", e.cyc, k),
                          64'(bus.rd_data[k*XLEN +: XLEN]),
                          64'(e.data[k*XLEN +: XLEN]));
                end
                check($sformatf("c%0d rd_busy", e.cyc), 64'(bus.rd_busy), 64'(e.busy));
                check($sformatf("c%0d iss_stall", e.cyc), 64'(bus.iss_stall), 64'(e.stall));
                check($sformatf("c%0d busy_cnt", e.cyc), 64'(bus.busy_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin
        int wa;
        int r0;
        int r1;
        rst_n       = 1'b0;
        bus.rd_addr = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.iss_en  = 1'b0;
        bus.iss_rd  = '0;
        bus.flush   = 1'b0;
        model_reset();

        // Power-on reset, then dirty some state before a mid-cycle reset.
        idle(2, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        step(2, 3, 1'b1, 3, 32'h0000_0777, 1'b1, 6, 1'b0);
        step(6, 3, 1'b1, 2, 32'h1111_2222, 1'b1, 8, 1'b0);
        idle(6, 8);

        // Mid-cycle async reset; sweep every address while held.
        @(posedge clk); #3 rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < NREGS / 2; i++) idle(2 * i, 2 * i + 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Write with same-cycle read (bypass), then stored value.
        step(5, 1, 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        idle(5, 5);

        // Register 0 ignores writes and issues.
        step(0, 0, 1'b1, 0, 32'h0000_1234, 1'b1, 0, 1'b0);
        idle(0, 5);

        // Scoreboard: issue, WAW stall, writeback clears combinationally.
        step(7, 0, 1'b0, 0, '0, 1'b1, 7, 1'b0);
        idle(7, 0);
        step(7, 0, 1'b0, 0, '0, 1'b1, 7, 1'b0);
        step(7, 0, 1'b1, 7, 32'h55, 1'b0, 0, 1'b0);
        idle(7, 0);

        // Collisions: issue + writeback same register; issue + flush.
        step(9, 0, 1'b0, 0, '0, 1'b1, 9, 1'b0);
        step(9, 0, 1'b1, 9, 32'hA, 1'b1, 9, 1'b0);
        idle(9, 9);
        step(4, 9, 1'b0, 0, '0, 1'b1, 4, 1'b0);
        step(3, 4, 1'b0, 0, '0, 1'b1, 3, 1'b1);
        idle(3, 4);
        idle(9, 0);

        // Fill every register, then flush.
        step(0, 0, 1'b1, 3, '0, 1'b1, 1, 1'b1);
        for (int i = 2; i < NREGS; i++) idle(i - 1, i);
        for (int i = 2; i < NREGS; i++) step(i, 1, 1'b0, 0, '0, 1'b1, i, 1'b0);
        idle(31, 1);
        step(31, 1, 1'b0, 0, '0, 1'b0, 0, 1'b1);
        idle(31, 1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            wa = int'($urandom_range(0, NREGS - 1));
            r0 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, NREGS - 1));
            r1 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, NREGS - 1));
            step(r0, r1, 1'($urandom_range(0, 1)), wa, $urandom(),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)),
                 ($urandom_range(0, 31) == 0));
        end
        idle(0, 0);

        // Drain the monitor with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check("drain queue", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
